// File: rtl/weight_stream_mux.sv
// Weight bank plus run sequencer: streams Count consecutive weights (wrapping
// modulo NUM_WEIGHTS) from Start_Addr through a registered valid/ready port.
module weight_stream_mux #(
  parameter int WGT_WIDTH   = 8,
  parameter int NUM_WEIGHTS = 50,
  parameter int SEL_WIDTH   = $clog2(NUM_WEIGHTS),
  parameter int CNT_WIDTH   = SEL_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Load_En,
  input  logic [SEL_WIDTH-1:0] Load_Addr,
  input  logic [WGT_WIDTH-1:0] Load_Data,
  input  logic                 Start,
  input  logic [SEL_WIDTH-1:0] Start_Addr,
  input  logic [CNT_WIDTH-1:0] Count,
  output logic                 Busy,
  output logic [WGT_WIDTH-1:0] Selected_Weight,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic                 Done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [SEL_WIDTH:0]   NUM_W   = NUM_WEIGHTS[SEL_WIDTH:0];
  localparam logic [SEL_WIDTH:0]   ONE_P   = {{SEL_WIDTH{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] ONE_C   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [WGT_WIDTH-1:0] bank_q [NUM_WEIGHTS];
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d, ptr_nxt, fetch_addr;
  logic [SEL_WIDTH:0]   ptr_inc, ptr_wrap;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [WGT_WIDTH-1:0] wgt_q, wgt_d, fetch_data;
  logic                 vld_q, vld_d, done_q, done_d;

  // 2^SEL_WIDTH < 2*NUM_WEIGHTS, so one conditional subtract covers every ptr,
  // including out-of-range start addresses.
  assign ptr_inc  = {1'b0, ptr_q} + ONE_P;
  assign ptr_wrap = ptr_inc - NUM_W;
  assign ptr_nxt  = (ptr_inc >= NUM_W) ? ptr_wrap[SEL_WIDTH-1:0] : ptr_inc[SEL_WIDTH-1:0];

  // Bank is read from its current register contents, so same-cycle writes are
  // not visible to the fetch.
  assign fetch_addr = (state_q == IDLE) ? Start_Addr : ptr_nxt;
  assign fetch_data = ({1'b0, fetch_addr} < NUM_W) ? bank_q[fetch_addr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_WEIGHTS; i++) bank_q[i] <= '0;
    end else if (Load_En && ({1'b0, Load_Addr} < NUM_W)) begin
      bank_q[Load_Addr] <= Load_Data;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    wgt_d   = wgt_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (Count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            ptr_d   = Start_Addr;
            rem_d   = Count;
            wgt_d   = fetch_data;
            vld_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (vld_q && Out_Ready) begin
          rem_d = rem_q - ONE_C;
          if (rem_q != ONE_C) begin
            ptr_d = ptr_nxt;
            wgt_d = fetch_data;
          end else begin
            vld_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      wgt_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      wgt_q   <= wgt_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign Busy            = (state_q == RUN);
  assign Selected_Weight = wgt_q;
  assign Out_Valid       = vld_q;
  assign Done            = done_q;

endmodule

// File: tb/tb_weight_stream_mux.sv
// Bench for weight_stream_mux: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the streaming rules.
module tb_weight_stream_mux;
  localparam int N = 50, W = 8, SW = 6, CW = 7;

  logic          clk = 1'b0;
  logic          reset, Load_En, Start, Out_Ready;
  logic [SW-1:0] Load_Addr, Start_Addr;
  logic [CW-1:0] Count;
  logic [W-1:0]  Load_Data, Selected_Weight;
  logic          Busy, Out_Valid, Done;

  int passed = 0, total = 0;

  weight_stream_mux #(.WGT_WIDTH(W), .NUM_WEIGHTS(N)) dut (
    .clk(clk), .reset(reset), .Load_En(Load_En), .Load_Addr(Load_Addr),
    .Load_Data(Load_Data), .Start(Start), .Start_Addr(Start_Addr), .Count(Count),
    .Busy(Busy), .Selected_Weight(Selected_Weight), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Done(Done)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [W-1:0] m_bank [N];
  logic [W-1:0] m_out;
  logic         m_vld, m_busy, m_done;
  int           m_ptr, m_rem;

  function automatic logic [W-1:0] mrd(input int a);
    if (a < N) return m_bank[a];
    return '0;
  endfunction

  // Advance model on current inputs, then clock the DUT and settle.
  task automatic tick();
    logic nd;
    if (reset) begin
      for (int i = 0; i < N; i++) m_bank[i] = '0;
      m_out = '0; m_vld = 0; m_busy = 0; m_done = 0; m_ptr = 0; m_rem = 0;
    end else begin
      nd = 0;
      if (!m_busy) begin
        if (Start) begin
          if (Count == 0) nd = 1;
          else begin
            m_busy = 1; m_ptr = Start_Addr; m_rem = Count;
            m_out = mrd(m_ptr); m_vld = 1;
          end
        end
      end else if (m_vld && Out_Ready) begin
        m_rem--;
        if (m_rem > 0) begin
          m_ptr = (m_ptr + 1) % N;
          m_out = mrd(m_ptr);
        end else begin
          m_vld = 0; m_busy = 0; nd = 1;
        end
      end
      m_done = nd;
      if (Load_En && Load_Addr < N) m_bank[Load_Addr] = Load_Data;
    end
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] got_q[$];
  logic [W-1:0] trace_q[$];
  int dones, busyc;

  // Issue a run and record handshaken values; mode 1 drops Out_Ready on cycles 1..3.
  task automatic run(input int addr, input int cnt, input int ncyc, input int mode);
    got_q.delete(); trace_q.delete(); dones = 0; busyc = 0;
    Start = 1; Start_Addr = SW'(addr); Count = CW'(cnt); Out_Ready = 1;
    tick();
    Start = 0;
    for (int k = 0; k < ncyc; k++) begin
      Out_Ready = (mode == 1) ? !(k >= 1 && k <= 3) : 1'b1;
      if (Out_Valid) trace_q.push_back(Selected_Weight);
      if (Out_Valid && Out_Ready) got_q.push_back(Selected_Weight);
      dones += int'(Done);
      busyc += int'(Busy);
      tick();
    end
    Out_Ready = 1;
  endtask

  task automatic test_reset();
    reset = 1; Load_En = 0; Load_Addr = 0; Load_Data = 0; Start = 0;
    Start_Addr = 0; Count = 0; Out_Ready = 0;
    repeat (3) tick();
    total++; if (Out_Valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", Out_Valid); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", Busy); else passed++;
    total++; if (Done !== 1'b0) $display("FAIL reset_done got=%b exp=0", Done); else passed++;
    total++; if (Selected_Weight !== 8'h00) $display("FAIL reset_weight got=%0d exp=0", Selected_Weight); else passed++;
    reset = 0;
    tick();
  endtask

  task automatic test_load_stream();
    for (int i = 0; i < N; i++) begin
      Load_En = 1; Load_Addr = SW'(i); Load_Data = W'(i + 1);
      tick();
    end
    Load_En = 0;
    run(3, 4, 6, 0);
    total++; if (got_q.size() !== 4) $display("FAIL stream_len got=%0d exp=4", got_q.size()); else passed++;
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      total++; if (got_q[k] !== W'(4 + k)) $display("FAIL stream_val[%0d] got=%0d exp=%0d", k, got_q[k], 4 + k); else passed++;
    end
    total++; if (dones !== 1) $display("FAIL stream_done got=%0d exp=1", dones); else passed++;
    total++; if (busyc !== 4) $display("FAIL stream_busy got=%0d exp=4", busyc); else passed++;
  endtask

  task automatic test_wrap();
    logic [W-1:0] exp [4];
    exp[0] = 49; exp[1] = 50; exp[2] = 1; exp[3] = 2;
    run(48, 4, 6, 0);
    total++; if (trace_q.size() !== 4) $display("FAIL wrap_bubble got=%0d valid cycles exp=4", trace_q.size()); else passed++;
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      total++; if (got_q[k] !== exp[k]) $display("FAIL wrap_val[%0d] got=%0d exp=%0d", k, got_q[k], exp[k]); else passed++;
    end
  endtask

  task automatic test_backpressure();
    int n5;
    run(3, 4, 9, 1);
    n5 = 0;
    foreach (trace_q[i]) if (trace_q[i] == 8'd5) n5++;
    total++; if (n5 !== 4) $display("FAIL bp_hold got=%0d cycles of 5 exp=4", n5); else passed++;
    total++; if (got_q.size() !== 4) $display("FAIL bp_len got=%0d exp=4", got_q.size()); else passed++;
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      total++; if (got_q[k] !== W'(4 + k)) $display("FAIL bp_val[%0d] got=%0d exp=%0d", k, got_q[k], 4 + k); else passed++;
    end
    total++; if (dones !== 1) $display("FAIL bp_done got=%0d exp=1", dones); else passed++;
  endtask

  task automatic test_collision();
    Out_Ready = 0;
    Start = 1; Start_Addr = 5; Count = 2;
    Load_En = 1; Load_Addr = 5; Load_Data = 8'hAA;
    tick();
    Start = 0;
    total++; if (Selected_Weight !== 8'd6) $display("FAIL coll_rbw got=%0d exp=6", Selected_Weight); else passed++;
    Load_Addr = 6; Load_Data = 8'h55;
    tick();
    Load_Addr = 5; Load_Data = 8'hBB;
    tick();
    total++; if (Selected_Weight !== 8'd6 || Out_Valid !== 1'b1)
      $display("FAIL coll_hold got=%0d/%b exp=6/1", Selected_Weight, Out_Valid); else passed++;
    Load_En = 0; Out_Ready = 1;
    tick();
    total++; if (Selected_Weight !== 8'h55) $display("FAIL coll_new got=%0h exp=55", Selected_Weight); else passed++;
    tick();
    total++; if (Done !== 1'b1 || Out_Valid !== 1'b0)
      $display("FAIL coll_end got done=%b valid=%b exp 1/0", Done, Out_Valid); else passed++;
    Load_En = 1; Load_Addr = 5; Load_Data = 6; tick();
    Load_Addr = 6; Load_Data = 7; tick();
    Load_En = 0;
  endtask

  task automatic test_edge();
    Start = 1; Start_Addr = 7; Count = 0;
    tick();
    Start = 0;
    total++; if (Done !== 1'b1 || Out_Valid !== 1'b0 || Busy !== 1'b0)
      $display("FAIL cnt0 got done=%b valid=%b busy=%b exp 1/0/0", Done, Out_Valid, Busy); else passed++;
    tick();
    total++; if (Done !== 1'b0 || Busy !== 1'b0) $display("FAIL cnt0_pulse got done=%b busy=%b exp 0/0", Done, Busy); else passed++;
    // Start while busy must not disturb the current run
    Out_Ready = 0; Start = 1; Start_Addr = 10; Count = 3;
    tick();
    Start_Addr = 20; Count = 5;
    tick();
    Start = 0;
    total++; if (Selected_Weight !== 8'd11 || Busy !== 1'b1)
      $display("FAIL busy_start got=%0d busy=%b exp=11/1", Selected_Weight, Busy); else passed++;
    got_q.delete(); Out_Ready = 1;
    for (int k = 0; k < 6; k++) begin
      if (Out_Valid) got_q.push_back(Selected_Weight);
      tick();
    end
    total++; if (got_q.size() !== 3 || got_q[0] !== 8'd11 || got_q[2] !== 8'd13)
      $display("FAIL busy_ignored got len=%0d exp len=3 values 11..13", got_q.size()); else passed++;
    run(50, 1, 3, 0);
    total++; if (got_q.size() !== 1 || got_q[0] !== 8'd0) $display("FAIL oor_start got len=%0d exp one zero", got_q.size()); else passed++;
    Load_En = 1; Load_Addr = 63; Load_Data = 8'hFF;
    tick();
    Load_En = 0;
    run(63, 1, 3, 0);
    total++; if (got_q.size() !== 1 || got_q[0] !== 8'd0) $display("FAIL oor_read got len=%0d exp one zero", got_q.size()); else passed++;
    begin
      int bad;
      run(0, N, N + 2, 0);
      bad = (got_q.size() == N) ? 0 : 1;
      foreach (got_q[i]) if (got_q[i] !== W'(i + 1)) bad++;
      total++; if (bad !== 0) $display("FAIL oor_write got %0d bad entries exp 0", bad); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    Out_Ready = 1; Start = 1; Start_Addr = 0; Count = 2;
    tick();
    Start = 0;
    tick(); tick();
    total++; if (Done !== 1'b1 || Busy !== 1'b0) $display("FAIL b2b_done got done=%b busy=%b exp 1/0", Done, Busy); else passed++;
    Start = 1; Start_Addr = 10; Count = 2;
    tick();
    Start = 0;
    total++; if (Out_Valid !== 1'b1 || Selected_Weight !== 8'd11 || Busy !== 1'b1)
      $display("FAIL b2b_first got valid=%b w=%0d busy=%b exp 1/11/1", Out_Valid, Selected_Weight, Busy); else passed++;
    tick(); tick();
    total++; if (Done !== 1'b1) $display("FAIL b2b_end got done=%b exp 1", Done); else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      Load_En = ($urandom_range(0, 3) == 0);
      Load_Addr = SW'($urandom_range(0, 63));
      Load_Data = W'($urandom);
      Start = ($urandom_range(0, 7) == 0);
      Start_Addr = SW'($urandom_range(0, 63));
      Count = CW'($urandom_range(0, 70));
      Out_Ready = ($urandom_range(0, 3) != 0);
      tick();
      total++; if (Out_Valid !== m_vld) $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, Out_Valid, m_vld); else passed++;
      total++; if (Busy !== m_busy) $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, Busy, m_busy); else passed++;
      total++; if (Done !== m_done) $display("FAIL rnd_done c=%0d got=%b exp=%b", c, Done, m_done); else passed++;
      if (m_vld) begin
        total++; if (Selected_Weight !== m_out) $display("FAIL rnd_weight c=%0d got=%0d exp=%0d", c, Selected_Weight, m_out); else passed++;
      end
    end
    Load_En = 0; Start = 0; Out_Ready = 1;
    repeat (80) tick();
  endtask

  task automatic test_reset_midrun();
    int bad;
    Out_Ready = 1; Start = 1; Start_Addr = 0; Count = 10;
    tick();
    Start = 0;
    tick(); tick();
    reset = 1;
    tick();
    total++; if (Out_Valid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0)
      $display("FAIL rst_mid got valid=%b busy=%b done=%b exp 0/0/0", Out_Valid, Busy, Done); else passed++;
    reset = 0;
    tick();
    total++; if (Done !== 1'b0) $display("FAIL rst_nodone got=%b exp=0", Done); else passed++;
    run(0, N, N + 2, 0);
    bad = (got_q.size() == N) ? 0 : 1;
    foreach (got_q[i]) if (got_q[i] !== 8'd0) bad++;
    total++; if (bad !== 0) $display("FAIL rst_bank got %0d bad entries exp 0", bad); else passed++;
    total++; if (dones !== 1) $display("FAIL rst_run_done got=%0d exp=1", dones); else passed++;
  endtask

  initial begin
    test_reset();
    test_load_stream();
    test_wrap();
    test_backpressure();
    test_collision();
    test_edge();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
